// File: rtl/writeback_buffer_if.sv
// Bundle of the writeback buffer's enqueue, commit, register-file write and
// forwarding signals; the master drives results in, the slave is the buffer.
interface writeback_buffer_if #(
    parameter int XLEN  = 64,
    parameter int DEPTH = 4
);
    logic                     in_valid;
    logic                     in_ready;
    logic [31:0]              in_inst;
    logic [XLEN-1:0]          in_pc;
    logic [XLEN-1:0]          in_value;
    logic                     in_wen;
    logic                     flush;
    logic                     out_valid;
    logic                     out_ready;
    logic [31:0]              out_inst;
    logic [XLEN-1:0]          out_pc;
    logic                     rf_we;
    logic [4:0]               rf_addr;
    logic [XLEN-1:0]          rf_data;
    logic [4:0]               fwd_addr;
    logic                     fwd_hit;
    logic [XLEN-1:0]          fwd_data;
    logic [$clog2(DEPTH):0]   count;

    modport master (
        output in_valid, in_inst, in_pc, in_value, in_wen, flush, out_ready, fwd_addr,
        input  in_ready, out_valid, out_inst, out_pc, rf_we, rf_addr, rf_data,
               fwd_hit, fwd_data, count
    );

    modport slave (
        input  in_valid, in_inst, in_pc, in_value, in_wen, flush, out_ready, fwd_addr,
        output in_ready, out_valid, out_inst, out_pc, rf_we, rf_addr, rf_data,
               fwd_hit, fwd_data, count
    );
endinterface

// File: rtl/writeback_buffer.sv
// In-order circular buffer between MEM/WB and the register file, with
// youngest-match forwarding over the entries still pending commit.
module writeback_buffer #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic              clk,
    input  logic              reset_n,
    writeback_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [31:0]     inst_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];
    logic [XLEN-1:0] val_mem  [DEPTH];
    logic [DEPTH-1:0] wen_mem;

    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic enq;
    logic deq;
    logic empty;
    logic in_wen_eff;

    assign empty         = (count_q == '0);
    assign bus.in_ready  = !bus.flush && ((count_q < CW'(DEPTH)) || bus.out_ready);
    assign bus.out_valid = !empty && !bus.flush;
    assign enq           = bus.in_valid && bus.in_ready;
    assign deq           = bus.out_valid && bus.out_ready;
    // x0 is never written or forwarded, so its write enable is dropped at entry
    assign in_wen_eff    = bus.in_wen && (bus.in_inst[11:7] != 5'd0);

    assign bus.out_inst = inst_mem[head_q];
    assign bus.out_pc   = pc_mem[head_q];
    assign bus.rf_we    = deq && wen_mem[head_q];
    assign bus.rf_addr  = inst_mem[head_q][11:7];
    assign bus.rf_data  = val_mem[head_q];
    assign bus.count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (bus.flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (enq) tail_d = tail_q + AW'(1);
            if (deq) head_d = head_q + AW'(1);
            case ({enq, deq})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Payload is unreset; validity comes only from head/count
    always_ff @(posedge clk) begin
        if (enq) begin
            inst_mem[tail_q] <= bus.in_inst;
            pc_mem[tail_q]   <= bus.in_pc;
            val_mem[tail_q]  <= bus.in_value;
            wen_mem[tail_q]  <= in_wen_eff;
        end
    end

    logic            fwd_hit_c;
    logic [XLEN-1:0] fwd_data_c;
    logic [AW-1:0]   fwd_idx;

    // Walk oldest to youngest so the last match (closest to tail) wins
    always_comb begin
        fwd_hit_c  = 1'b0;
        fwd_data_c = '0;
        fwd_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + AW'(i);
            if ((CW'(i) < count_q) && wen_mem[fwd_idx] &&
                (inst_mem[fwd_idx][11:7] == bus.fwd_addr) && (bus.fwd_addr != 5'd0)) begin
                fwd_hit_c  = 1'b1;
                fwd_data_c = val_mem[fwd_idx];
            end
        end
    end

    assign bus.fwd_hit  = fwd_hit_c;
    assign bus.fwd_data = fwd_data_c;
endmodule

// File: doc/writeback_buffer.md
WRITEBACK_BUFFER -- requirements
Module: writeback_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning queue entries; it is a power of two and at least 2.
REQ-002 SHALL have parameter XLEN, default 64, meaning data and PC width.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port in_valid, input, 1 bit: the MEM/WB result is presented.
REQ-006 SHALL have port in_ready, output, 1 bit: the buffer accepts the result this cycle.
REQ-007 SHALL have port in_inst, input, 32 bits: instruction word; dest = in_inst[11:7].
REQ-008 SHALL have port in_pc, input, XLEN bits: instruction PC.
REQ-009 SHALL have port in_value, input, XLEN bits: result to write.
REQ-010 SHALL have port in_wen, input, 1 bit: the instruction writes a register.
REQ-011 SHALL have port flush, input, 1 bit: discard all pending entries.
REQ-012 SHALL have port out_valid, output, 1 bit: the head entry is offered for commit.
REQ-013 SHALL have port out_ready, input, 1 bit: the commit side takes the head.
REQ-014 SHALL have ports out_inst (output, 32 bits) and out_pc (output, XLEN bits): head instruction and PC.
REQ-015 SHALL have ports rf_we (output, 1 bit), rf_addr (output, 5 bits) and rf_data (output, XLEN bits): the register-file write port.
REQ-016 SHALL have port fwd_addr, input, 5 bits: source register being looked up.
REQ-017 SHALL have ports fwd_hit (output, 1 bit) and fwd_data (output, XLEN bits): the forwarding result.
REQ-018 SHALL have port count, output, $clog2(DEPTH)+1 bits: the current occupancy.

Function
REQ-019 SHALL hold an in-order circular FIFO with head and tail pointers of $clog2(DEPTH) bits that wrap modulo DEPTH, plus an occupancy counter.
REQ-020 SHALL define enq = in_valid && in_ready and deq = out_valid && out_ready.
REQ-021 SHALL drive in_ready = (count < DEPTH) || out_ready when not empty; in_ready SHALL be 0 while flush = 1.
REQ-022 SHALL store each entry's wen as in_wen && (dest != 0), so that x0 is never written or forwarded.
REQ-023 SHALL drive out_valid = (count != 0) && !flush; out_inst and out_pc SHALL come from the head entry.
REQ-024 SHALL drive the register-file write port combinationally: rf_we = deq && head.wen, rf_addr = head.dest, rf_data = head.value.
REQ-025 On simultaneous enq and deq, count SHALL be unchanged and both pointers SHALL advance, including when full.
REQ-026 Latency SHALL be one cycle: an entry enqueued at edge N is visible on out_valid in the cycle after edge N; there is no bypass from in_* to out_*.
REQ-027 On flush = 1, at the next edge count and both pointers SHALL return to 0; no enq or deq occurs that cycle, and rf_we SHALL be 0.
REQ-028 Forwarding SHALL be combinational over valid entries only: fwd_hit = 1 iff some entry has wen = 1 and dest = fwd_addr != 0.
REQ-029 When several entries match, fwd_data SHALL come from the youngest one (closest to tail); fwd_data SHALL be 0 when fwd_hit = 0.
REQ-030 Forwarding SHALL still see the head entry during the cycle it commits; an entry enqueued this cycle SHALL NOT be seen until the next cycle.
REQ-031 Entry payload storage SHALL NOT require reset; validity SHALL be derived solely from the pointers and count.

Reset
REQ-032 While reset_n = 0, count, head and tail SHALL be 0 immediately, without waiting for a clock edge.
REQ-033 Outputs during and after reset SHALL be: out_valid = 0, rf_we = 0, fwd_hit = 0, fwd_data = 0, in_ready = 1.
REQ-034 Reset asserted mid-operation SHALL discard all pending entries; the first post-reset enqueue lands in slot 0.

Verification
REQ-035 Fill and drain: DEPTH = 4, out_ready = 0, enqueue pc 0x100, 0x104, 0x108, 0x10C -> count = 4, in_ready = 0; then out_ready = 1 -> commits in that pc order, one per cycle, and count reaches 0.
REQ-036 Full with concurrent traffic: with the buffer full, drive in_valid = 1 and out_ready = 1 for 8 cycles -> count stays at 4 throughout, the pointers wrap twice, and the commit order matches the enqueue order.
REQ-037 Youngest-match forwarding: enqueue x5 = 0x11, x5 = 0x22, x6 = 0x33 and set fwd_addr = 5 -> fwd_hit = 1, fwd_data = 0x22; with fwd_addr = 0 -> fwd_hit = 0.
REQ-038 x0 suppression: enqueue dest = 0 with in_wen = 1 and value 0xDEAD -> it commits with rf_we = 0, and fwd_addr = 0 never hits.
REQ-039 Flush: with 3 entries queued, pulse flush together with in_valid = 1 and out_ready = 1 -> no rf_we, no enqueue, and count = 0 on the next cycle.
REQ-040 Asynchronous reset: drop reset_n between clock edges with 2 entries pending -> out_valid and count go to 0 before the next clk edge.
